// File: rtl/pcpu_defs.sv
// Shared pcpu definitions: datapath widths, opcode and general-register
// encodings, and the default store-buffer depth.
package pcpu_defs;

  localparam int PCPU_DW  = 16;
  localparam int PCPU_AW  = 8;
  localparam int SB_DEPTH = 4;

  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_HALT  = 5'b00001,
    OP_LOAD  = 5'b00010,
    OP_STORE = 5'b00011,
    OP_LDIH  = 5'b10000,
    OP_ADD   = 5'b01000,
    OP_ADDI  = 5'b01001,
    OP_ADDC  = 5'b10001,
    OP_SUB   = 5'b01010,
    OP_SUBI  = 5'b01011,
    OP_SUBC  = 5'b10010,
    OP_CMP   = 5'b01100,
    OP_AND   = 5'b01101,
    OP_OR    = 5'b01110,
    OP_XOR   = 5'b01111,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00110,
    OP_SLA   = 5'b00101,
    OP_SRA   = 5'b00111,
    OP_JUMP  = 5'b11000,
    OP_JMPR  = 5'b11001,
    OP_BZ    = 5'b11010,
    OP_BNZ   = 5'b11011,
    OP_BN    = 5'b11100,
    OP_BNN   = 5'b11101,
    OP_BC    = 5'b11110,
    OP_BNC   = 5'b11111
  } opcode_t;

  typedef enum logic [2:0] {
    GR0 = 3'd0,
    GR1 = 3'd1,
    GR2 = 3'd2,
    GR3 = 3'd3,
    GR4 = 3'd4,
    GR5 = 3'd5,
    GR6 = 3'd6,
    GR7 = 3'd7
  } gr_t;

endpackage

// File: rtl/pcpu_sb_match.sv
// Store-buffer address match: finds the newest valid entry whose address
// equals the lookup address, scanning from head (oldest) towards tail.
module pcpu_sb_match
  import pcpu_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = PCPU_AW
) (
  input  logic [DEPTH-1:0][AW-1:0]   i_addr,
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [AW-1:0]              i_lookup,
  output logic                       o_hit,
  output logic [$clog2(DEPTH)-1:0]   o_idx
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_slot;

  // Later matches in age order overwrite earlier ones, so the newest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = i_head + PW'(k);
      if (i_valid[w_slot] && (i_addr[w_slot] == i_lookup)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
    end
  end

endmodule

// File: rtl/pcpu_store_buffer.sv
// Posted-store buffer between the pcpu MEM stage and a slower data RAM:
// FIFO of {addr,data} drained over req/ack, with load forwarding.
module pcpu_store_buffer
  import pcpu_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = PCPU_AW,
  parameter int DW    = PCPU_DW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [AW-1:0]            d_addr,
  input  logic [DW-1:0]            d_dataout,
  input  logic                     d_we,
  output logic [DW-1:0]            d_datain,
  output logic                     stall,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_waddr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [CW-1:0]            r_count;
  logic                     r_overflow;

  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic [DEPTH-1:0]         w_valid;
  logic                     w_hit;
  logic [PW-1:0]            w_hit_idx;
  logic [PW-1:0]            w_rel;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && mem_ack;
  // A full buffer still accepts a store when the head retires this cycle.
  assign w_push = d_we && (!w_full || w_pop);
  assign w_drop = d_we && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity comes from head/count alone.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= d_addr;
      r_data[r_tail] <= d_dataout;
    end
  end

  always_comb begin
    w_valid = '0;
    w_rel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rel      = PW'(i) - r_head;
      w_valid[i] = ({1'b0, w_rel} < r_count);
    end
  end

  pcpu_sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .i_addr   (r_addr),
    .i_valid  (w_valid),
    .i_head   (r_head),
    .i_lookup (d_addr),
    .o_hit    (w_hit),
    .o_idx    (w_hit_idx)
  );

  assign d_datain  = w_hit ? r_data[w_hit_idx] : mem_rdata;
  assign mem_raddr = d_addr;
  assign mem_req   = (r_count != '0);
  assign mem_waddr = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign stall     = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pcpu_store_buffer.sv
// Bench for pcpu_store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pcpu_store_buffer;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        stall;
  logic [7:0]  mem_raddr;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        overflow;

  pcpu_store_buffer dut (
    .clock     (clock),
    .reset     (reset),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we),
    .d_datain  (d_datain),
    .stall     (stall),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .count     (count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [7:0] a, input logic [15:0] rd);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return q[i].d;
    return rd;
  endfunction

  // Drive one cycle, check everything visible before the edge, then advance.
  task automatic cycle(input logic we, input logic [7:0] a, input logic [15:0] d,
                       input logic ack, input logic [15:0] rd, input logic rst);
    int  n;
    logic pop, push;
    d_we = we; d_addr = a; d_dataout = d; mem_ack = ack; mem_rdata = rd; reset = rst;
    #1;
    n = q.size();
    chk("datain", d_datain, fwd(a, rd));
    chk("raddr", mem_raddr, a);
    chk("req", mem_req, n != 0);
    chk("stall", stall, n == DEPTH);
    chk("count", count, n);
    chk("overflow", overflow, m_ovf);
    if (n != 0) begin
      chk("waddr", mem_waddr, q[0].a);
      chk("wdata", mem_wdata, q[0].d);
    end
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (n != 0) && ack;
      push = we && ((n < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{a: a, d: d});
      else if (we) m_ovf = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_ovf = 1'b0;
    reset = 1'b1; d_we = 1'b0; d_addr = '0; d_dataout = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", overflow, 0);

    // single store then drain
    cycle(1'b1, 8'h02, 16'h5BC7, 1'b1, 16'h0, 1'b0);
    chk("t1_req", mem_req, 1);
    chk("t1_waddr", mem_waddr, 8'h02);
    chk("t1_wdata", mem_wdata, 16'h5BC7);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("t1_count", count, 0);
    chk("t1_req0", mem_req, 0);

    // forwarding priority
    cycle(1'b1, 8'h02, 16'h1111, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h02, 16'h2222, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h03, 16'h3333, 1'b0, 16'h0, 1'b0);
    d_we = 1'b0; d_addr = 8'h02; mem_rdata = 16'h0000; #1;
    chk("fwd_newest", d_datain, 16'h2222);
    d_addr = 8'h04; mem_rdata = 16'h5A5A; #1;
    chk("fwd_miss", d_datain, 16'h5A5A);
    repeat (3) cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("fwd_drained", count, 0);

    // fill, stall, overflow
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(5 + i), 16'(16'hA000 + i), 1'b0, 16'h0, 1'b0);
    chk("fill_stall", stall, 1);
    chk("fill_count", count, 4);
    cycle(1'b1, 8'h09, 16'h9999, 1'b0, 16'h0, 1'b0);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 4);
    d_we = 1'b0; d_addr = 8'h09; mem_rdata = 16'h7777; #1;
    chk("drop_nofwd", d_datain, 16'h7777);
    cycle(1'b0, 8'h00, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // full with simultaneous pop and push
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(5 + i), 16'(16'hB000 + i), 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h0A, 16'hABCD, 1'b1, 16'h0, 1'b0);
    chk("pp_count", count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", mem_waddr, 8'h06);
    repeat (3) cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("pp_last_addr", mem_waddr, 8'h0A);
    chk("pp_last_data", mem_wdata, 16'hABCD);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("pp_empty", count, 0);

    // backpressure
    cycle(1'b1, 8'h11, 16'hC001, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h12, 16'hC002, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 16'h0, 1'b0, 16'h0, 1'b0);
      chk("bp_waddr", mem_waddr, 8'h11);
      chk("bp_wdata", mem_wdata, 16'hC001);
    end
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("bp_next_addr", mem_waddr, 8'h12);
    chk("bp_next_data", mem_wdata, 16'hC002);
    chk("bp_count1", count, 1);
    cycle(1'b0, 8'h00, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("bp_count0", count, 0);

    // reset mid-operation, with a push and ack in the same cycle
    cycle(1'b1, 8'h21, 16'hD001, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h22, 16'hD002, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h23, 16'hD003, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 8'h24, 16'hDDDD, 1'b1, 16'h0, 1'b1);
    chk("mr_count", count, 0);
    chk("mr_req", mem_req, 0);
    chk("mr_stall", stall, 0);
    chk("mr_ovf", overflow, 0);
    reset = 1'b0; d_we = 1'b0; d_addr = 8'h22; mem_rdata = 16'h1234; #1;
    chk("mr_nofwd", d_datain, 16'h1234);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, 8'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 99) < 45, 16'($urandom), $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpu_store_buffer.md
Name: pcpu_store_buffer

Overview:
- Sits directly downstream of the pcpu MEM stage, on the data-memory side: d_addr, d_dataout and d_we come in, and d_datain goes back to the core.
- Decouples CPU stores from a slower backing data RAM. Posted stores are queued in a small FIFO and drained to the RAM over a req/ack write handshake.
- Loads are served by forwarding the newest matching buffered store, or else from the RAM's combinational read port.
- Asserts stall when the buffer is full; the top level ANDs stall into the pcpu enable.

Parameters:
- DEPTH, 4, number of store-buffer entries (power of two, at least 2).
- AW, 8, data address width; matches pcpu d_addr.
- DW, 16, data word width; matches the pcpu datapath.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset. Same name as the core's reset port, but the polarity and synchronicity here are fixed.
- d_addr  in  AW  CPU data address, used for both loads and stores.
- d_dataout  in  DW  CPU store data.
- d_we  in  1  CPU store strobe; one store per cycle while high.
- d_datain  out  DW  load data returned to the CPU (combinational).
- stall  out  1  buffer full; the CPU must hold off stores.
- mem_raddr  out  AW  backing RAM read address; equals d_addr.
- mem_rdata  in  DW  backing RAM combinational read data.
- mem_req  out  1  write request to the backing RAM.
- mem_waddr  out  AW  write address, taken from the head entry.
- mem_wdata  out  DW  write data, taken from the head entry.
- mem_ack  in  1  backing RAM has accepted the write this cycle.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky error flag: a store was dropped.

Behaviour:
- Storage: circular FIFO of {addr, data}, with head pointer, tail pointer and count registers.
- Push: on a clock edge where d_we=1 and (count<DEPTH or pop occurs this cycle), write {d_addr, d_dataout} at tail, then tail++ (wrapping modulo DEPTH).
- Pop: on a clock edge where mem_req=1 and mem_ack=1, head++ (wrapping modulo DEPTH).
- Simultaneous push and pop: count is unchanged. When full, the push is accepted because of the same-cycle pop.
- Push while full with no pop: the store is dropped, count is unchanged, and overflow is set to 1. overflow holds until reset.
- mem_req = (count != 0). It is derived from registered state only.
- mem_waddr and mem_wdata show the head entry and stay stable while mem_req=1 and mem_ack=0.
- mem_ack while mem_req=0 is ignored.
- Latency: a store pushed at edge N raises mem_req after edge N if the buffer was empty. The minimum drain is one entry per cycle while mem_ack is held high.
- stall = (count == DEPTH). It is registered-state derived; there is no combinational path from d_we.
- Load forwarding (combinational): compare d_addr against all valid entries.
  - On any match, d_datain = data of the newest matching entry (closest to tail).
  - Otherwise, d_datain = mem_rdata.
  - An entry being popped in the current cycle is still valid for forwarding in that cycle.
  - A store being pushed in the current cycle is not forwarded until the next cycle.
- mem_raddr = d_addr at all times.
- Reset (synchronous): head=0, tail=0, count=0, overflow=0, giving mem_req=0 and stall=0. Entry contents are don't-care.
- Reset mid-handshake: pending stores are discarded and mem_req is 0 after the reset edge. The backing RAM must tolerate an abandoned request.
- Reset has priority over a push or pop occurring in the same cycle.
- Arithmetic: pointers are log2(DEPTH) bits wide and wrap naturally. count is one bit wider. No address or data arithmetic is performed.

Decomposition:
- Shared package pcpu_defs: opcode defines, DW=16, AW=8, and the pcpu gr encodings. The store-buffer DEPTH default also lives there.
- One sub-module, pcpu_sb_match:
  - Inputs: entry address vector, valid vector, head pointer, and lookup address.
  - Outputs: hit flag and the index of the newest match.
  - The top level contains the FIFO registers, the handshake logic and the output mux.

Test Plan:
- Single store, then drain: reset, then d_we=1, d_addr=02, d_dataout=5BC7 for one cycle, with mem_ack=1.
  - Required: next cycle, mem_req=1 with waddr=02 and wdata=5BC7.
  - Required: following cycle, count=0 and mem_req=0.
- Forwarding priority: with mem_ack=0, store 02<-1111, then 02<-2222, then 03<-3333. Drive d_addr=02 and mem_rdata=0000.
  - Required: d_datain=2222.
  - Required: d_addr=04 gives d_datain=mem_rdata.
- Fill and stall: with mem_ack=0, issue 4 stores.
  - Required: stall=1 and count=4.
  - A 5th store (addr 09) is dropped: overflow=1, count=4, and d_addr=09 forwards mem_rdata.
- Full with simultaneous pop and push: buffer full, mem_ack=1 and d_we=1 with 0A<-ABCD in the same cycle.
  - Required: count stays 4, overflow stays 0, and 0A<-ABCD drains last, in FIFO order.
- Backpressure: mem_ack held at 0 for 5 cycles with 2 entries queued.
  - Required: mem_waddr and mem_wdata stay unchanged throughout.
  - Required: after the ack pulses, entries retire in order, one per acked cycle.
- Reset mid-operation: 3 entries queued, then reset=1 for one cycle.
  - Required: count=0, mem_req=0, stall=0 and overflow=0 on the next cycle, and forwarding no longer hits.
